// File: rtl/led_driver_pkg.sv
// Shared types for the LED debug output path: LED vector width, the
// brightness word, the driver state encoding and the all-off pin pattern.
package led_driver_pkg;

    localparam int led_w        = 6;
    localparam int PWM_BITS_DEF = 4;

    typedef logic [led_w-1:0]        led_t;
    typedef logic [PWM_BITS_DEF-1:0] pwm_t;

    typedef enum logic [0:0] {
        LAMP_TEST = 1'b0,
        RUN       = 1'b1
    } state_t;

    // Pin pattern that leaves every LED dark for the given polarity.
    function automatic led_t off_pattern(input bit active_low);
        return active_low ? {led_w{1'b1}} : {led_w{1'b0}};
    endfunction

endpackage

// File: rtl/led_driver_if.sv
// Bundle between the data-memory LED register and the LED driver.
// The master side supplies the pattern and dimming; the slave side is the
// driver, which returns the refresh pulse and the physical pin levels.
interface led_driver_if
    import led_driver_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) ();

    led_t                led_in;
    logic [PWM_BITS-1:0] brightness;
    logic                hold;
    logic                refresh_tick;
    led_t                leds;

    modport master (
        output led_in, brightness, hold,
        input  refresh_tick, leds
    );

    modport slave (
        input  led_in, brightness, hold,
        output refresh_tick, leds
    );

endinterface

// File: rtl/led_driver_tick_divider.sv
// Periodic tick generator: a registered one-cycle pulse every DIV cycles,
// the first one DIV cycles after reset release. Reusable for other
// periodic debug logic.
module tick_divider #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt_r;
    logic          tick_r;

    // Down-counter that reloads at zero and flags the reload one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= CW'(DIV - 1);
            tick_r    <= 1'b0;
        end else if (div_cnt_r == CW'(0)) begin
            div_cnt_r <= CW'(DIV - 1);
            tick_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r - CW'(1);
            tick_r    <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/led_driver.sv
// LED driver: samples the logical LED pattern once per refresh period into
// a shadow register, runs a power-on lamp test, applies PWM dimming and
// drives the pins with the configured polarity.
// Optional build macro LED_DRIVER_CHANGE_FLASH_EN: bits that changed at the
// last snapshot are shown at full duty for one refresh period.
module led_driver
    import led_driver_pkg::*;
#(
    parameter int CLK_HZ              = 27_000_000,
    parameter int REFRESH_HZ          = 2,
    parameter int PWM_BITS            = 4,
    parameter int LAMP_TEST_REFRESHES = 2,
    parameter int ACTIVE_LOW          = 1
) (
    input  logic         clk,
    input  logic         rst,
    led_driver_if.slave  bus
);

    localparam int   DIV     = CLK_HZ / REFRESH_HZ;
    localparam int   LW      = (LAMP_TEST_REFRESHES > 2) ? $clog2(LAMP_TEST_REFRESHES) : 1;
    localparam led_t OFF_PAT = off_pattern(ACTIVE_LOW != 0);

    logic                tick_s;
    state_t              state_r, state_s;
    logic [LW-1:0]       lamp_cnt_r;
    logic                snap_s;
    logic                hold_clr_s;
    logic                lamp_dec_s;
    led_t                shadow_r;
    logic [PWM_BITS-1:0] bright_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                duty_on_s;
    led_t                flash_s;
    led_t                lit_s;
    led_t                leds_r;

    tick_divider #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Free-running PWM phase counter, wraps all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LAMP_TEST;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-tick actions: lamp countdown, snapshot or hold.
    always_comb begin
        state_s    = state_r;
        snap_s     = 1'b0;
        hold_clr_s = 1'b0;
        lamp_dec_s = 1'b0;
        case (state_r)
            LAMP_TEST: begin
                if (tick_s) begin
                    if (lamp_cnt_r == LW'(0)) begin
                        state_s = RUN;
                        snap_s  = 1'b1;
                    end else begin
                        lamp_dec_s = 1'b1;
                    end
                end else begin
                    state_s = LAMP_TEST;
                end
            end
            RUN: begin
                if (tick_s) begin
                    if (bus.hold) begin
                        hold_clr_s = 1'b1;
                    end else begin
                        snap_s = 1'b1;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = LAMP_TEST;
            end
        endcase
    end

    // Lamp-test period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamp_cnt_r <= LW'(LAMP_TEST_REFRESHES - 1);
        end else if (lamp_dec_s) begin
            lamp_cnt_r <= lamp_cnt_r - LW'(1);
        end else begin
            lamp_cnt_r <= lamp_cnt_r;
        end
    end

    // Shadow pattern and brightness captured on a snapshot tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= '0;
            bright_r <= '1;
        end else if (snap_s) begin
            shadow_r <= bus.led_in;
            bright_r <= bus.brightness;
        end else begin
            shadow_r <= shadow_r;
            bright_r <= bright_r;
        end
    end

`ifdef LED_DRIVER_CHANGE_FLASH_EN
    led_t changed_r;

    // Bits that differ between the new and old shadow; a hold tick clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_r <= '0;
        end else if (snap_s) begin
            changed_r <= bus.led_in ^ shadow_r;
        end else if (hold_clr_s) begin
            changed_r <= '0;
        end else begin
            changed_r <= changed_r;
        end
    end

    assign flash_s = changed_r;
`else
    assign flash_s = '0;
`endif

    // Lit decision: full pattern during lamp test, dimmed shadow afterwards.
    always_comb begin
        duty_on_s = (bright_r == {PWM_BITS{1'b1}}) || (pwm_cnt_r < bright_r);
        lit_s     = '1;
        if (state_r == RUN) begin
            lit_s = shadow_r & ({led_w{duty_on_s}} | flash_s);
        end else begin
            lit_s = '1;
        end
    end

    // Registered pin levels with polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_r <= OFF_PAT;
        end else begin
            leds_r <= lit_s ^ OFF_PAT;
        end
    end

    assign bus.leds         = leds_r;
    assign bus.refresh_tick = tick_s;

endmodule

// File: doc/led_driver.md
Name: led_driver

Overview:
- Downstream consumer of the data-memory LED debug register.
- Converts the raw `led_t` value into the physical LED pins.
- Contains the update-rate divider, a power-on lamp test, PWM dimming and output polarity, replacing the ad-hoc counter logic at top level.
- Sits between `dmem` and the board `leds` port.

Parameters:
- CLK_HZ, 27_000_000: input clock frequency.
- REFRESH_HZ, 2: display update rate; DIV = CLK_HZ/REFRESH_HZ cycles per refresh, must be ≥2.
- PWM_BITS, 4: brightness resolution.
- LAMP_TEST_REFRESHES, 2: refresh periods with all LEDs on after reset.
- ACTIVE_LOW, 1: 1 means the pin drives 0 to light an LED.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- led_in  in  led_t (6)  logical LED pattern from `dmem`; 1 = lit.
- brightness  in  PWM_BITS  duty level; 0 = off, all-ones = always on.
- hold  in  1  freezes the displayed pattern while high.
- refresh_tick  out  1  one-cycle pulse when the shadow pattern updates.
- leds  out  led_t (6)  physical LED pins.

Behaviour:
- Clocking and reset: one clock domain (`clk`); reset is asynchronous and active-high (`rst`). All flops reset asynchronously.
- Reset values:
  - `leds` = all-off pattern: all ones if ACTIVE_LOW, else zeros.
  - `refresh_tick` = 0; shadow = 0; bright_q = all ones.
  - div_cnt = DIV-1; pwm_cnt = 0; state = LAMP_TEST; lamp_cnt = LAMP_TEST_REFRESHES-1.
- Divider:
  - div_cnt decrements each cycle.
  - At 0 it reloads DIV-1 and raises `refresh_tick` for exactly one cycle, on the cycle after div_cnt==0 (registered).
  - First tick comes DIV cycles after reset release.
- PWM counter: PWM_BITS wide, free-running, wraps all-ones→0.
- LAMP_TEST state:
  - Logical pattern is all ones at full duty.
  - Each tick decrements lamp_cnt; the tick with lamp_cnt==0 moves to RUN.
  - That tick also performs the first normal snapshot.
  - `hold` is ignored in this state.
- RUN state:
  - On a tick with hold=0: shadow <= led_in and bright_q <= brightness.
  - On a tick with hold=1: shadow and bright_q are unchanged; `refresh_tick` still pulses.
  - `led_in` and `brightness` changes between ticks have no visible effect.
- Lit bit: shadow[i] && (bright_q == all-ones || pwm_cnt < bright_q).
  - bright_q == 0 means all LEDs off.
- Output: `leds` = lit XOR {6{ACTIVE_LOW}}, registered, one cycle after the lit decision.
- Reset mid-operation: immediate all-off output and return to LAMP_TEST; any partial refresh period is discarded.
- No state transitions except LAMP_TEST→RUN and reset.

Optional Feature:
- Macro: `LED_DRIVER_CHANGE_FLASH_EN`.
- When defined:
  - At each RUN snapshot, changed = new_shadow XOR old_shadow is registered.
  - For the following refresh period, bits with changed[i]=1 display at full duty regardless of bright_q. This applies to both newly-on and newly-off bits: a newly-off bit is shown off.
  - Effectively only newly-lit bits are forced bright.
  - A hold tick clears changed to 0.
- When undefined: no changed register; all bits obey bright_q.

Decomposition:
- Shared types package gains:
  - `led_w` constant (6).
  - `state` enum {LAMP_TEST, RUN}.
  - `pwm_t` typedef sized by PWM_BITS default.
- `led_t` is reused from the existing package.
- One sub-module is natural: `tick_divider` (parameter DIV, ports clk, rst, tick), reusable for other periodic debug logic.

Test Plan (CLK_HZ=100, REFRESH_HZ=10 → DIV=10, PWM_BITS=4, LAMP_TEST_REFRESHES=2, ACTIVE_LOW=1):
- Reset behaviour: assert rst for 3 cycles, release → `leds`=6'b111111 while rst high. After release `leds`=6'b000000 (lamp test) for ticks 1–2. `refresh_tick` pulses at cycles 10, 20, 30 after release.
- Snapshot timing: led_in=6'b101010, brightness=4'hF → after the 2nd tick `leds`=6'b010101 constantly. Changing led_in to 6'b000001 mid-period → no change until the next tick, then 6'b111110.
- PWM duty: brightness=4'h4, shadow=6'b000001 → `leds`[0] low for exactly 4 of every 16 cycles. brightness=0 → `leds`[0] always high. brightness=4'hF → always low.
- Hold: hold=1 across ticks 3–5 with led_in toggling → `leds` unchanged, `refresh_tick` still pulses; release hold → next tick adopts the current led_in.
- Reset mid-operation: rst asserted at cycle 35 → `leds`=6'b111111 same cycle. On release, lamp test repeats and first RUN snapshot occurs at tick 2.
- `LED_DRIVER_CHANGE_FLASH_EN` defined: brightness=4'h1, shadow 6'b000000→6'b000011 → bits 0–1 fully on for 10 cycles, then duty 1/16.
